toggle_decoder: RTL and testbench
=================================

TOGGLE_DECODER -- requirements
Module: toggle_decoder

Interface
REQ-001 Parameter SYNC, default 8'hA5: frame sync byte, matched against the last 8 decoded bits.
REQ-002 Parameter FRAME_LEN, default 4: data bytes per frame, legal range 1..255.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port en, input, 1 bit: bit strobe; the line is sampled only in cycles with en=1.
REQ-006 Port line, input, 1 bit: toggle-encoded serial line (a T-flip-flop output), where toggle = 1 and no toggle = 0.
REQ-007 Port data, output, 8 bits: received byte.
REQ-008 Port valid, output, 1 bit: data holds an unconsumed byte.
REQ-009 Port ready, input, 1 bit: consumer accepts data when valid=1 and ready=1 on the same edge.
REQ-010 Port in_frame, output, 1 bit: high while the state machine is in DATA.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse after the last byte of a frame.
REQ-012 Port overrun, output, 1 bit: sticky flag, set when a completed byte is dropped.

Function
REQ-013 On each en=1 cycle, decoded bit b = line XOR line_q, and line_q <= line; on en=0 cycles, line_q, the shift register, the counters and the state all hold.
REQ-014 The state machine has two states, HUNT and DATA.
REQ-015 HUNT: shreg <= {b, shreg[7:1]} (LSB first); after the shift, if the new shreg == SYNC, go to DATA with bit_cnt=0 and byte_cnt=0.
REQ-016 In HUNT, valid, data and overrun are not modified by sync search.
REQ-017 DATA: each decoded bit shifts into the assembly register LSB first and bit_cnt increments.
REQ-018 DATA byte completion: on the 8th bit (bit_cnt==7), the byte is complete in that same cycle.
REQ-019 Completed-byte handling:
- If valid=0, or valid=1 and ready=1 in that cycle: data <= byte, valid <= 1.
- Otherwise: the byte is dropped, overrun <= 1, and the existing data/valid are unchanged.
REQ-020 In every byte-completion case, bit_cnt wraps to 0 and byte_cnt increments.
REQ-021 When the completed byte is byte number FRAME_LEN:
- return to HUNT;
- clear shreg to 8'h00;
- pulse frame_done for exactly one cycle, in the next cycle.
REQ-022 valid clears one edge after valid=1 and ready=1 unless REQ-019 reloads it on that same edge; ready while valid=0 has no effect.
REQ-023 Latency: valid rises on the edge that samples the 8th data bit, i.e. data is visible the cycle after that en cycle.
REQ-024 SYNC detection is never suppressed in HUNT, including immediately after a frame ends; bits of a following SYNC that arrived before the frame ended are discarded.
REQ-025 in_frame = (state == DATA).
REQ-026 Counter widths: bit_cnt is 3 bits; byte_cnt is 8 bits and is compared for equality to FRAME_LEN.

Reset
REQ-027 On rst=1 at a clock edge:
- state = HUNT, line_q = 0, shreg = 0, bit_cnt = 0, byte_cnt = 0;
- data = 8'h00, valid = 0, in_frame = 0, frame_done = 0, overrun = 0.
REQ-028 rst asserted mid-frame aborts the frame; any partial byte is discarded and no frame_done is generated.
REQ-029 rst has priority over en, ready and all other inputs.

Verification
REQ-030 Basic frame: rst, then en=1 every cycle, line encoding SYNC=A5 then bytes 11,22,33,44 LSB first, ready=1 -> valid pulses four times with data 11,22,33,44; frame_done pulses once, 1 cycle after the 44 byte; in_frame is high from after the sync until the last byte.
REQ-031 Back-pressure: ready=0 throughout the same frame -> data=11, valid=1 held; overrun=1 after byte 22 completes; data remains 11.
REQ-032 Simultaneous accept and new byte: hold ready=0 until the cycle byte 22 completes, then pulse ready=1 in that cycle -> data=22, valid stays 1, overrun stays 0.
REQ-033 Strobe gating: en toggles 1/0 each cycle with line held constant on en=0 cycles -> decoded bytes identical to REQ-030.
REQ-034 Hunt robustness:
- Stimulus: preamble FF,00,5A (no A5 window), then A5 + 4 bytes -> exactly one frame decoded.
- Stimulus: all-zero line (no toggles) -> in_frame and valid stay 0.
REQ-035 Reset mid-frame: assert rst for 1 cycle after 2 bytes of a frame -> all outputs 0; a subsequent full frame decodes normally and produces 4 valid bytes.

Source files
------------

// File: rtl/toggle_decoder.sv
// Toggle-encoded serial receiver: recovers bits from a T-flip-flop line, hunts for
// a sync byte, then assembles FRAME_LEN LSB-first bytes behind a valid/ready output.
module toggle_decoder #(
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       line,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       in_frame,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN);

  state_t     r_state;
  logic       r_line_q;
  logic [7:0] r_shreg;
  logic [7:0] r_asm;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic [7:0] r_byte_p0;
  logic       r_vld_p0;
  logic       r_frame_done;
  logic       r_overrun;

  logic       w_bit;
  logic [7:0] w_shreg_nxt;
  logic [7:0] w_byte;
  logic [7:0] w_byte_cnt_nxt;
  logic       w_accept;
  logic       w_room;

  assign w_bit          = line ^ r_line_q;
  assign w_shreg_nxt    = {w_bit, r_shreg[7:1]};
  assign w_byte         = {w_bit, r_asm[7:1]};
  assign w_byte_cnt_nxt = r_byte_cnt + 8'd1;
  assign w_accept       = r_vld_p0 & ready;
  // The output slot is free if empty or being drained on this very edge.
  assign w_room         = ~r_vld_p0 | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_line_q     <= 1'b0;
      r_shreg      <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 8'd0;
      r_byte_p0    <= 8'h00;
      r_vld_p0     <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_vld_p0 <= 1'b0;
      end
      if (en) begin
        r_line_q <= line;
        case (r_state)
          HUNT: begin
            r_shreg <= w_shreg_nxt;
            if (w_shreg_nxt == SYNC) begin
              r_state    <= DATA;
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= 8'd0;
            end
          end
          DATA: begin
            r_asm     <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              // byte complete: output stage p0 takes it or it is dropped
              if (w_room) begin
                r_byte_p0 <= w_byte;
                r_vld_p0  <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
              r_byte_cnt <= w_byte_cnt_nxt;
              if (w_byte_cnt_nxt == LAST_BYTE) begin
                r_state      <= HUNT;
                r_shreg      <= 8'h00;
                r_frame_done <= 1'b1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign data       = r_byte_p0;
  assign valid      = r_vld_p0;
  assign in_frame   = (r_state == DATA);
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder: table of whole-frame scenarios plus
// hand-written sequences for byte-boundary timing, reset abort and re-sync.
module tb_toggle_decoder;

  logic       clk;
  logic       rst;
  logic       en;
  logic       line;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       in_frame;
  logic       frame_done;
  logic       overrun;

  logic       line_r;
  int         n_chk;
  int         n_err;
  int         fd_cnt;
  int         if_cnt;
  logic [7:0] acc_q[$];

  toggle_decoder #(.SYNC(8'hA5), .FRAME_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .line       (line),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: an accept happens on the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (valid && ready) acc_q.push_back(data);
    if (frame_done) fd_cnt++;
    if (in_frame) if_cnt++;
  end

  typedef struct {
    logic [23:0] pre;
    int          pre_n;
    bit          sync_on;
    logic [31:0] payload;
    bit          gap;
    bit          rdy;
    int          exp_n;
    int          exp_fd;
    int          exp_if;
    bit          exp_ovr;
    bit          exp_vld;
    logic [7:0]  exp_dat;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    acc_q.delete();
    fd_cnt = 0;
    if_cnt = 0;
  endtask

  task automatic do_reset(input bit r);
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0; line = 1'b0; line_r = 1'b0; ready = r;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset(input string name);
    chk(name, 32'({data, valid, in_frame, frame_done, overrun}), 32'h0);
  endtask

  task automatic send_bit(input logic b, input bit gap, input bit r);
    @(posedge clk); #1;
    en = 1'b1; line_r = line_r ^ b; line = line_r; ready = r;
    if (gap) begin
      @(posedge clk); #1;
      en = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap, input bit r);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap, r);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] bv;
    logic [7:0] sv;
    n_chk = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; line = 1'b0; line_r = 1'b0; ready = 1'b0;
    clr_mon();

    //            pre        n  syn payload       gap rdy n  fd if  ovr vld dat
    tbl[0] = '{24'h000000, 0, 1'b1, 32'h44332211, 1'b0, 1'b1, 4, 1, 32, 1'b0, 1'b0, 8'h44};
    tbl[1] = '{24'h000000, 0, 1'b1, 32'h44332211, 1'b1, 1'b1, 4, 1, 64, 1'b0, 1'b0, 8'h44};
    tbl[2] = '{24'h5A00FF, 3, 1'b1, 32'h44332211, 1'b0, 1'b1, 4, 1, 32, 1'b0, 1'b0, 8'h44};
    tbl[3] = '{24'h000000, 0, 1'b0, 32'h00000000, 1'b0, 1'b1, 0, 0, 0,  1'b0, 1'b0, 8'h00};
    tbl[4] = '{24'h000000, 0, 1'b1, 32'h44332211, 1'b0, 1'b0, 0, 1, 32, 1'b1, 1'b1, 8'h11};
    tbl[5] = '{24'h000000, 0, 1'b1, 32'h00FF8001, 1'b0, 1'b1, 4, 1, 32, 1'b0, 1'b0, 8'h00};

    for (int t = 0; t < 6; t++) begin
      do_reset(tbl[t].rdy);
      check_reset($sformatf("row%0d reset", t));
      clr_mon();
      for (int i = 0; i < tbl[t].pre_n; i++) send_byte(tbl[t].pre[8*i +: 8], tbl[t].gap, tbl[t].rdy);
      if (tbl[t].sync_on) send_byte(8'hA5, tbl[t].gap, tbl[t].rdy);
      for (int i = 0; i < 4; i++) send_byte(tbl[t].payload[8*i +: 8], tbl[t].gap, tbl[t].rdy);
      idle(4);
      chk($sformatf("row%0d nbytes", t), acc_q.size(), tbl[t].exp_n);
      for (int i = 0; i < tbl[t].exp_n && i < acc_q.size(); i++)
        chk($sformatf("row%0d byte%0d", t, i), 32'(acc_q[i]), 32'(tbl[t].payload[8*i +: 8]));
      chk($sformatf("row%0d frame_done", t), fd_cnt, tbl[t].exp_fd);
      chk($sformatf("row%0d in_frame", t), if_cnt, tbl[t].exp_if);
      chk($sformatf("row%0d overrun", t), 32'(overrun), 32'(tbl[t].exp_ovr));
      chk($sformatf("row%0d valid", t), 32'(valid), 32'(tbl[t].exp_vld));
      chk($sformatf("row%0d data", t), 32'(data), 32'(tbl[t].exp_dat));
    end

    // Accept and new byte on the same edge: slot reloads, no overrun.
    do_reset(1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    send_byte(8'h11, 1'b0, 1'b0);
    idle(2);
    chk("hold valid", 32'(valid), 32'd1);
    chk("hold data", 32'(data), 32'h11);
    bv = 8'h22;
    for (int i = 0; i < 8; i++) send_bit(bv[i], 1'b0, (i == 7));
    @(posedge clk); #1;
    en = 1'b0; ready = 1'b0;
    chk("same-edge data", 32'(data), 32'h22);
    chk("same-edge valid", 32'(valid), 32'd1);
    chk("same-edge overrun", 32'(overrun), 32'd0);

    // frame_done timing and immediate re-sync after a frame.
    do_reset(1'b1);
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    send_byte(8'h33, 1'b0, 1'b1);
    bv = 8'h44;
    sv = 8'hA5;
    for (int i = 0; i < 8; i++) send_bit(bv[i], 1'b0, 1'b1);
    @(negedge clk);
    chk("pre-last valid", 32'(valid), 32'd0);
    chk("pre-last frame_done", 32'(frame_done), 32'd0);
    chk("pre-last in_frame", 32'(in_frame), 32'd1);
    send_bit(sv[0], 1'b0, 1'b1);
    @(negedge clk);
    chk("last data", 32'(data), 32'h44);
    chk("last valid", 32'(valid), 32'd1);
    chk("fd pulse", 32'(frame_done), 32'd1);
    chk("fd in_frame", 32'(in_frame), 32'd0);
    send_bit(sv[1], 1'b0, 1'b1);
    @(negedge clk);
    chk("fd one cycle", 32'(frame_done), 32'd0);
    for (int i = 2; i < 8; i++) send_bit(sv[i], 1'b0, 1'b1);
    send_byte(8'h55, 1'b0, 1'b1);
    @(posedge clk); #1;
    en = 1'b0;
    chk("resync data", 32'(data), 32'h55);
    chk("resync valid", 32'(valid), 32'd1);
    chk("resync in_frame", 32'(in_frame), 32'd1);

    // Reset mid-frame, then a clean frame.
    do_reset(1'b1);
    send_byte(8'hA5, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0, 1'b1);
    send_byte(8'h22, 1'b0, 1'b1);
    do_reset(1'b1);
    check_reset("midframe reset");
    clr_mon();
    send_byte(8'hA5, 1'b0, 1'b1);
    sv = 8'hAA; send_byte(sv, 1'b0, 1'b1);
    sv = 8'hBB; send_byte(sv, 1'b0, 1'b1);
    sv = 8'hCC; send_byte(sv, 1'b0, 1'b1);
    sv = 8'hDD; send_byte(sv, 1'b0, 1'b1);
    idle(4);
    chk("after reset nbytes", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      chk("after reset b0", 32'(acc_q[0]), 32'hAA);
      chk("after reset b1", 32'(acc_q[1]), 32'hBB);
      chk("after reset b2", 32'(acc_q[2]), 32'hCC);
      chk("after reset b3", 32'(acc_q[3]), 32'hDD);
    end
    chk("after reset frame_done", fd_cnt, 1);
    chk("after reset overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
